sec_ksa_sched: RTL and testbench

// Shares one pipelined SecKSA instance between N_REQ masked-addition requesters in the B2A converter.

---
 rtl/sec_ksa_sched_pkg.sv | 26 ++
 rtl/sec_ksa_sched_if.sv | 35 +++
 rtl/sec_ksa_sched_rr_arb.sv | 53 +++++
 rtl/sec_ksa_sched.sv | 113 +++++++++++
 tb/tb_sec_ksa_sched.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sec_ksa_sched_pkg.sv
// Shared constants and types for the SecKSA request scheduler in the B2A converter.
package sec_ksa_sched_pkg;

    localparam int K_WIDTH   = 32;
    localparam int N_SHARES  = 3;
    localparam int MASKWIDTH = K_WIDTH * N_SHARES;
    localparam int RANDNUM   = 27;
    localparam int RNDWIDTH  = K_WIDTH * RANDNUM;
    localparam int N_REQ     = 2;

    // SecKSA depth: one Kogge-Stone level per address bit plus the input stage.
    function automatic int ksa_lat(input int k);
        return $clog2(k) + 1;
    endfunction

    localparam int KSA_LAT = ksa_lat(K_WIDTH);
    localparam int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef logic [ID_W-1:0] req_id_t;

    typedef struct packed {
        logic    vld;
        req_id_t id;
    } tag_t;

endpackage

// File: rtl/sec_ksa_sched_if.sv
// Bus bundle between requesters, PRNG, SecKSA and the scheduler.
interface sec_ksa_sched_if;
    import sec_ksa_sched_pkg::*;

    logic [N_REQ-1:0]           req_vld;
    logic [N_REQ*MASKWIDTH-1:0] req_x;
    logic [N_REQ*MASKWIDTH-1:0] req_y;
    logic [N_REQ-1:0]           req_rdy;
    logic [RNDWIDTH-1:0]        rnd_in;
    logic                       rnd_vld;
    logic                       rnd_rdy;
    logic                       ksa_dvld;
    logic                       ksa_ena;
    logic [RNDWIDTH-1:0]        ksa_rnd;
    logic [MASKWIDTH-1:0]       ksa_x;
    logic [MASKWIDTH-1:0]       ksa_y;
    logic [MASKWIDTH-1:0]       ksa_z;
    logic                       ksa_ovld;
    logic [N_REQ-1:0]           rsp_vld;
    logic [MASKWIDTH-1:0]       rsp_z;
    logic                       err;

    modport slave (
        input  req_vld, req_x, req_y, rnd_in, rnd_vld, ksa_z, ksa_ovld,
        output req_rdy, rnd_rdy, ksa_dvld, ksa_ena, ksa_rnd, ksa_x, ksa_y,
               rsp_vld, rsp_z, err
    );

    modport master (
        output req_vld, req_x, req_y, rnd_in, rnd_vld, ksa_z, ksa_ovld,
        input  req_rdy, rnd_rdy, ksa_dvld, ksa_ena, ksa_rnd, ksa_x, ksa_y,
               rsp_vld, rsp_z, err
    );

endinterface

// File: rtl/sec_ksa_sched_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the winner on issue.
module sec_ksa_sched_rr_arb #(
    parameter int N = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  i_req,
    input  logic          i_en,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_gnt_idx,
    output logic          o_issue
);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_idx;
    logic          w_found;
    logic          w_issue;
    logic [N-1:0]  w_gnt;

    // Search for the first requester at or after the pointer.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && i_req[(int'(r_ptr) + k) % N]) begin
                w_found = 1'b1;
                w_idx   = PW'((int'(r_ptr) + k) % N);
            end else begin
                w_found = w_found;
                w_idx   = w_idx;
            end
        end
        w_issue = w_found & i_en;
        w_gnt   = w_issue ? (N'(1) << w_idx) : '0;
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_issue) begin
            r_ptr <= (int'(w_idx) == N - 1) ? '0 : w_idx + PW'(1);
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign o_gnt     = w_gnt;
    assign o_gnt_idx = w_idx;
    assign o_issue   = w_issue;

endmodule

// File: rtl/sec_ksa_sched.sv
// Shares one pipelined SecKSA between N_REQ requesters; shares are only ever moved as whole vectors.
module sec_ksa_sched
    import sec_ksa_sched_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    sec_ksa_sched_if.slave  bus
);

    logic [N_REQ-1:0]     w_gnt;
    req_id_t              w_idx;
    logic                 w_issue;
    logic [MASKWIDTH-1:0] w_x;
    logic [MASKWIDTH-1:0] w_y;
    tag_t                 w_head;

    logic                 r_ksa_dvld;
    req_id_t              r_ksa_id;
    logic [MASKWIDTH-1:0] r_ksa_x;
    logic [MASKWIDTH-1:0] r_ksa_y;
    logic [RNDWIDTH-1:0]  r_ksa_rnd;
    tag_t                 r_tag [KSA_LAT];
    logic [N_REQ-1:0]     r_rsp_vld;
    logic [MASKWIDTH-1:0] r_rsp_z;
    logic                 r_err;

    // Issue requires both a valid requester and an unused randomness set.
    sec_ksa_sched_rr_arb #(.N(N_REQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (bus.req_vld),
        .i_en      (bus.rnd_vld),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_idx),
        .o_issue   (w_issue)
    );

    assign w_x = bus.req_x[int'(w_idx)*MASKWIDTH +: MASKWIDTH];
    assign w_y = bus.req_y[int'(w_idx)*MASKWIDTH +: MASKWIDTH];

    // Operand registers; idle cycles zero the bus so no stale shares linger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ksa_dvld <= 1'b0;
            r_ksa_id   <= '0;
            r_ksa_x    <= '0;
            r_ksa_y    <= '0;
            r_ksa_rnd  <= '0;
        end else if (w_issue) begin
            r_ksa_dvld <= 1'b1;
            r_ksa_id   <= w_idx;
            r_ksa_x    <= w_x;
            r_ksa_y    <= w_y;
            r_ksa_rnd  <= bus.rnd_in;
        end else begin
            r_ksa_dvld <= 1'b0;
            r_ksa_id   <= '0;
            r_ksa_x    <= '0;
            r_ksa_y    <= '0;
            r_ksa_rnd  <= '0;
        end
    end

    // Tag pipe mirrors the SecKSA depth, entering alongside ksa_dvld.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < KSA_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= '{vld: r_ksa_dvld, id: r_ksa_id};
            for (int i = 1; i < KSA_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign w_head = r_tag[KSA_LAT-1];

    // Return register and sticky mismatch flag between ksa_ovld and the tag head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_vld <= '0;
            r_rsp_z   <= '0;
            r_err     <= 1'b0;
        end else begin
            if (bus.ksa_ovld && w_head.vld) begin
                r_rsp_vld <= N_REQ'(1) << w_head.id;
                r_rsp_z   <= bus.ksa_z;
            end else begin
                r_rsp_vld <= '0;
                r_rsp_z   <= '0;
            end
            if (bus.ksa_ovld != w_head.vld) begin
                r_err <= 1'b1;
            end else begin
                r_err <= r_err;
            end
        end
    end

    assign bus.req_rdy  = w_gnt;
    assign bus.rnd_rdy  = w_issue;
    assign bus.ksa_dvld = r_ksa_dvld;
    assign bus.ksa_ena  = 1'b1;
    assign bus.ksa_rnd  = r_ksa_rnd;
    assign bus.ksa_x    = r_ksa_x;
    assign bus.ksa_y    = r_ksa_y;
    assign bus.rsp_vld  = r_rsp_vld;
    assign bus.rsp_z    = r_rsp_z;
    assign bus.err      = r_err;

endmodule

// File: tb/tb_sec_ksa_sched.sv
// Scoreboard bench for sec_ksa_sched with a behavioural SecKSA and requester model.
module tb_sec_ksa_sched;
    import sec_ksa_sched_pkg::*;

    localparam int RSP_LAT = 8;
    localparam int KSA_D   = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sec_ksa_sched_if bus();

    sec_ksa_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int id; logic [31:0] sum; int due; } rsp_t;
    typedef struct { logic [95:0] x; logic [95:0] y; logic [863:0] rnd; int due; } op_t;
    typedef struct { bit v; logic [31:0] sum; } kp_t;

    rsp_t rsp_q[$];
    op_t  op_q[$];
    kp_t  kpipe[KSA_D+1];
    int   rr_ptr = 0;
    bit   inject = 1'b0;
    logic [31:0] op_x[2];
    logic [31:0] op_y[2];

    task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [95:0] share(input logic [31:0] v);
        logic [31:0] m0 = $urandom();
        logic [31:0] m1 = $urandom();
        return {v ^ m0 ^ m1, m1, m0};
    endfunction

    function automatic logic [31:0] unshare(input logic [95:0] s);
        return s[31:0] ^ s[63:32] ^ s[95:64];
    endfunction

    task automatic set_op(input int i, input logic [31:0] xv, input logic [31:0] yv);
        op_x[i] = xv;
        op_y[i] = yv;
        bus.req_x[i*96 +: 96] = share(xv);
        bus.req_y[i*96 +: 96] = share(yv);
    endtask

    // Drive one cycle at the negedge, check the combinational grant and record expectations.
    task automatic step(input logic [1:0] vld, input logic rv, output int win);
        logic [1:0] exp_g;
        bus.req_vld = vld;
        bus.rnd_vld = rv;
        for (int w = 0; w < 27; w++) bus.rnd_in[w*32 +: 32] = $urandom();
        #1;
        win = -1;
        if ((vld != 2'b00) && rv) begin
            for (int k = 0; k < 2; k++) begin
                if (win < 0 && vld[(rr_ptr + k) % 2]) win = (rr_ptr + k) % 2;
            end
        end
        exp_g = (win >= 0) ? 2'(1 << win) : 2'b00;
        check(bus.req_rdy == exp_g, "grant", 128'(bus.req_rdy), 128'(exp_g));
        check(bus.rnd_rdy == (win >= 0), "rnd_rdy", 128'(bus.rnd_rdy), 128'(win >= 0));
        if (win >= 0) begin
            rsp_q.push_back('{win, op_x[win] + op_y[win], cyc + RSP_LAT});
            op_q.push_back('{bus.req_x[win*96 +: 96], bus.req_y[win*96 +: 96], bus.rnd_in, cyc + 1});
            rr_ptr = (win + 1) % 2;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        int w;
        for (int i = 0; i < n; i++) step(2'b00, 1'b0, w);
    endtask

    task automatic drain();
        int w;
        for (int i = 0; i < 40 && rsp_q.size() > 0; i++) step(2'b00, 1'b0, w);
        check(rsp_q.size() == 0, "drain_timeout", 128'(rsp_q.size()), 128'd0);
        rsp_q.delete();
    endtask

    // Behavioural SecKSA: fixed latency, recombine, add, re-share with fresh masks.
    initial begin
        bus.ksa_ovld = 1'b0;
        bus.ksa_z    = '0;
        for (int k = 0; k <= KSA_D; k++) kpipe[k] = '{1'b0, 32'd0};
        forever begin
            @(negedge clk);
            for (int k = KSA_D; k > 0; k--) kpipe[k] = kpipe[k-1];
            kpipe[0] = '{bus.ksa_dvld, unshare(bus.ksa_x) + unshare(bus.ksa_y)};
            if (!rst_n) begin
                for (int k = 0; k <= KSA_D; k++) kpipe[k] = '{1'b0, 32'd0};
            end
            bus.ksa_ovld = kpipe[KSA_D].v | inject;
            bus.ksa_z    = kpipe[KSA_D].v ? share(kpipe[KSA_D].sum) : 96'd0;
            inject       = 1'b0;
        end
    end

    // Monitor: operand bus contents and returned sums against the queues.
    initial begin
        op_t  o;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (op_q.size() > 0 && op_q[0].due == cyc) begin
                    o = op_q.pop_front();
                    check(bus.ksa_dvld == 1'b1, "ksa_dvld", 128'(bus.ksa_dvld), 128'd1);
                    check(bus.ksa_x == o.x, "ksa_x", 128'(bus.ksa_x), 128'(o.x));
                    check(bus.ksa_y == o.y, "ksa_y", 128'(bus.ksa_y), 128'(o.y));
                    check(bus.ksa_rnd == o.rnd, "ksa_rnd", 128'(bus.ksa_rnd), 128'(o.rnd));
                end else begin
                    check(bus.ksa_dvld == 1'b0 && bus.ksa_x == '0 && bus.ksa_y == '0 && bus.ksa_rnd == '0,
                          "idle_bus", 128'(bus.ksa_x), 128'd0);
                end
                if (bus.rsp_vld != 2'b00) begin
                    if (rsp_q.size() == 0) begin
                        check(1'b0, "rsp_spurious", 128'(bus.rsp_vld), 128'd0);
                    end else begin
                        r = rsp_q.pop_front();
                        check(bus.rsp_vld == 2'(1 << r.id), "rsp_id", 128'(bus.rsp_vld), 128'(1 << r.id));
                        check(unshare(bus.rsp_z) == r.sum, "rsp_sum", 128'(unshare(bus.rsp_z)), 128'(r.sum));
                        check(cyc == r.due, "rsp_latency", 128'(cyc), 128'(r.due));
                    end
                end else if (rsp_q.size() > 0 && rsp_q[0].due < cyc) begin
                    r = rsp_q.pop_front();
                    check(1'b0, "rsp_missing", 128'd0, 128'(r.due));
                end
            end
        end
    end

    initial begin
        int w;
        logic [1:0] pend;
        rst_n       = 1'b0;
        bus.req_vld = '0;
        bus.rnd_vld = 1'b0;
        bus.req_x   = '0;
        bus.req_y   = '0;
        bus.rnd_in  = '0;
        repeat (3) @(negedge clk);
        #1;
        check(bus.req_rdy == 2'b00, "rst_req_rdy", 128'(bus.req_rdy), 128'd0);
        check(bus.rnd_rdy == 1'b0, "rst_rnd_rdy", 128'(bus.rnd_rdy), 128'd0);
        check(bus.ksa_dvld == 1'b0, "rst_dvld", 128'(bus.ksa_dvld), 128'd0);
        check(bus.ksa_ena == 1'b1, "rst_ena", 128'(bus.ksa_ena), 128'd1);
        check(bus.ksa_x == '0 && bus.ksa_rnd == '0, "rst_ksa_bus", 128'(bus.ksa_x), 128'd0);
        check(bus.rsp_vld == 2'b00 && bus.rsp_z == '0, "rst_rsp", 128'(bus.rsp_vld), 128'd0);
        check(bus.err == 1'b0, "rst_err", 128'(bus.err), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single op 5 + 7, then the wrap case from requester 1.
        set_op(0, 32'd5, 32'd7);
        step(2'b01, 1'b1, w);
        idle(10);
        set_op(1, 32'hFFFF_FFFF, 32'd1);
        step(2'b10, 1'b1, w);
        idle(10);

        // Both requesters valid back-to-back.
        for (int i = 0; i < 4; i++) begin
            set_op(0, $urandom(), $urandom());
            set_op(1, $urandom(), $urandom());
            step(2'b11, 1'b1, w);
        end
        idle(10);

        // Randomness starvation holds off issue.
        set_op(0, $urandom(), $urandom());
        set_op(1, $urandom(), $urandom());
        repeat (3) step(2'b11, 1'b0, w);
        step(2'b11, 1'b1, w);
        idle(10);

        // Random traffic with valid held until accepted.
        pend = 2'b00;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 3) != 0) begin
                    set_op(i, $urandom(), $urandom());
                    pend[i] = 1'b1;
                end
            end
            step(pend, $urandom_range(0, 3) != 0, w);
            if (w >= 0) pend[w] = 1'b0;
        end
        drain();
        check(bus.err == 1'b0, "err_after_traffic", 128'(bus.err), 128'd0);

        // Reset three cycles after an accept discards the op and the pointer.
        set_op(0, $urandom(), $urandom());
        step(2'b01, 1'b1, w);
        idle(2);
        rst_n = 1'b0;
        rsp_q.delete();
        op_q.delete();
        rr_ptr = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(12);
        check(bus.err == 1'b0, "err_after_reset", 128'(bus.err), 128'd0);
        set_op(0, $urandom(), $urandom());
        set_op(1, $urandom(), $urandom());
        step(2'b11, 1'b1, w);
        idle(1);
        drain();

        // Spurious ovld with an empty tag pipe.
        #1;
        inject = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check(bus.err == 1'b1, "err_set", 128'(bus.err), 128'd1);
        @(negedge clk);
        idle(5);
        #1;
        check(bus.err == 1'b1, "err_sticky", 128'(bus.err), 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
